// File: rtl/bus_arbiter.sv
// Shares the single external memory bus between the instruction fetch port and the data port.
// It runs one bus transaction at a time and holds each result until the consuming stage advances.
module bus_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall_i,
  input  logic        flush_i,
  input  logic        inst_req_i,
  input  logic [31:0] inst_addr_i,
  output logic [31:0] inst_data_o,
  output logic        inst_stallreq_o,
  input  logic        data_req_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_sel_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic [31:0] data_rdata_o,
  output logic        data_stallreq_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [3:0]  bus_sel_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_ack_i,
  input  logic [31:0] bus_rdata_i
);

  typedef enum logic [1:0] {IDLE, INST_BUSY, DATA_BUSY} state_t;

  state_t      state, state_next;
  logic        inst_done, data_done, drop;
  logic [31:0] inst_buf, data_buf;
  logic        launch_data, launch_inst, ack_done, keep_result;
  logic        unused_stall;

  assign unused_stall = ^{stall_i[5], stall_i[3:2], stall_i[0]};

  assign inst_stallreq_o = inst_req_i & ~inst_done;
  assign data_stallreq_o = data_req_i & ~data_done;
  assign inst_data_o     = inst_buf;
  assign data_rdata_o    = data_buf;

  // A completion flushed before or with its ack still finishes on the bus but delivers nothing.
  assign keep_result = ack_done & ~drop & ~flush_i;

  // NOTE: every signal driven here gets a default first, so no path through the case can infer a latch.
  always_comb begin
    state_next  = state;
    launch_data = 1'b0;
    launch_inst = 1'b0;
    ack_done    = 1'b0;
    case (state)
      IDLE: begin
        if (!flush_i) begin
          if (data_req_i && !data_done) begin
            launch_data = 1'b1;
            state_next  = DATA_BUSY;
          end else if (inst_req_i && !inst_done) begin
            launch_inst = 1'b1;
            state_next  = INST_BUSY;
          end
        end
      end
      INST_BUSY, DATA_BUSY: begin
        if (bus_ack_i) begin
          ack_done   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus_req_o   <= 1'b0;
      bus_we_o    <= 1'b0;
      bus_sel_o   <= 4'b0000;
      bus_addr_o  <= 32'h0;
      bus_wdata_o <= 32'h0;
      inst_done   <= 1'b0;
      data_done   <= 1'b0;
      drop        <= 1'b0;
      inst_buf    <= 32'h0;
      data_buf    <= 32'h0;
    end else begin
      if (launch_data) begin
        bus_req_o   <= 1'b1;
        bus_we_o    <= data_we_i;
        bus_sel_o   <= data_sel_i;
        bus_addr_o  <= data_addr_i;
        bus_wdata_o <= data_wdata_i;
      end else if (launch_inst) begin
        bus_req_o   <= 1'b1;
        bus_we_o    <= 1'b0;
        bus_sel_o   <= 4'b1111;
        bus_addr_o  <= inst_addr_i;
        bus_wdata_o <= 32'h0;
      end else if (ack_done) begin
        bus_req_o   <= 1'b0;
      end

      if (ack_done)                      drop <= 1'b0;
      else if (state != IDLE && flush_i) drop <= 1'b1;

      if (keep_result && state == INST_BUSY) inst_buf <= bus_rdata_i;
      if (keep_result && state == DATA_BUSY) data_buf <= bus_rdata_i;

      // Done flags survive a stall of their own stage so an access is never repeated.
      if (flush_i || (inst_done && !stall_i[1]))  inst_done <= 1'b0;
      else if (keep_result && state == INST_BUSY) inst_done <= 1'b1;

      if (flush_i || (data_done && !stall_i[4]))  data_done <= 1'b0;
      else if (keep_result && state == DATA_BUSY) data_done <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios followed by random traffic,
// all compared each cycle against a transaction-level model of the shared bus.
module tb_bus_arbiter;

  logic        clk, rst;
  logic [5:0]  stall_i;
  logic        flush_i;
  logic        inst_req_i;
  logic [31:0] inst_addr_i;
  logic [31:0] inst_data_o;
  logic        inst_stallreq_o;
  logic        data_req_i, data_we_i;
  logic [3:0]  data_sel_i;
  logic [31:0] data_addr_i, data_wdata_i, data_rdata_o;
  logic        data_stallreq_o;
  logic        bus_req_o, bus_we_o;
  logic [3:0]  bus_sel_o;
  logic [31:0] bus_addr_o, bus_wdata_o;
  logic        bus_ack_i;
  logic [31:0] bus_rdata_i;

  int total = 0;
  int bad   = 0;
  int wr_count = 0;

  bus_arbiter dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
    .inst_req_i(inst_req_i), .inst_addr_i(inst_addr_i), .inst_data_o(inst_data_o),
    .inst_stallreq_o(inst_stallreq_o),
    .data_req_i(data_req_i), .data_we_i(data_we_i), .data_sel_i(data_sel_i),
    .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i), .data_rdata_o(data_rdata_o),
    .data_stallreq_o(data_stallreq_o),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_sel_o(bus_sel_o),
    .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o),
    .bus_ack_i(bus_ack_i), .bus_rdata_i(bus_rdata_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: at most one outstanding bus transaction, plus one held result per port.
  typedef struct {
    bit          active;
    bit          is_data;
    bit          stale;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  txn_t        cur;
  bit          m_idone, m_ddone;
  logic [31:0] m_ibuf, m_dbuf;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    cur = '{active: 1'b0, is_data: 1'b0, stale: 1'b0, we: 1'b0, sel: 4'h0, addr: 32'h0, wdata: 32'h0};
    m_idone = 1'b0;
    m_ddone = 1'b0;
    m_ibuf  = 32'h0;
    m_dbuf  = 32'h0;
  endtask

  task automatic model_check();
    check("bus_req",       32'(bus_req_o),       32'(cur.active));
    check("bus_we",        32'(bus_we_o),        32'(cur.we));
    check("bus_sel",       32'(bus_sel_o),       32'(cur.sel));
    check("bus_addr",      bus_addr_o,           cur.addr);
    check("bus_wdata",     bus_wdata_o,          cur.wdata);
    check("inst_stallreq", 32'(inst_stallreq_o), 32'(inst_req_i & ~m_idone));
    check("data_stallreq", 32'(data_stallreq_o), 32'(data_req_i & ~m_ddone));
    check("inst_data",     inst_data_o,          m_ibuf);
    check("data_rdata",    data_rdata_o,         m_dbuf);
  endtask

  task automatic model_update();
    bit n_idone, n_ddone;
    if (rst) begin
      model_reset();
      return;
    end
    // A held result stays while its stage is stalled; a flush discards it.
    n_idone = m_idone && !flush_i && stall_i[1];
    n_ddone = m_ddone && !flush_i && stall_i[4];
    if (!cur.active) begin
      if (!flush_i && data_req_i && !m_ddone)
        cur = '{active: 1'b1, is_data: 1'b1, stale: 1'b0, we: data_we_i, sel: data_sel_i,
                addr: data_addr_i, wdata: data_wdata_i};
      else if (!flush_i && inst_req_i && !m_idone)
        cur = '{active: 1'b1, is_data: 1'b0, stale: 1'b0, we: 1'b0, sel: 4'hF,
                addr: inst_addr_i, wdata: 32'h0};
    end else if (bus_ack_i) begin
      if (!cur.stale && !flush_i) begin
        if (cur.is_data) begin m_dbuf = bus_rdata_i; n_ddone = 1'b1; end
        else             begin m_ibuf = bus_rdata_i; n_idone = 1'b1; end
      end
      cur.active = 1'b0;
      cur.stale  = 1'b0;
    end else if (flush_i) begin
      cur.stale = 1'b1;
    end
    m_idone = n_idone;
    m_ddone = n_ddone;
  endtask

  // One clock cycle: compare at the falling edge, advance the model, then step past the rising edge.
  task automatic cyc();
    @(negedge clk);
    model_check();
    if (bus_req_o === 1'b1 && bus_we_o === 1'b1 && bus_ack_i === 1'b1) wr_count++;
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    stall_i = 6'h0; flush_i = 1'b0;
    inst_req_i = 1'b0; inst_addr_i = 32'h0;
    data_req_i = 1'b0; data_we_i = 1'b0; data_sel_i = 4'h0;
    data_addr_i = 32'h0; data_wdata_i = 32'h0;
    bus_ack_i = 1'b0; bus_rdata_i = 32'h0;
  endtask

  initial begin
    rst = 1'b1;
    clear_in();
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    #1;
    check("rst_bus_req", 32'(bus_req_o), 0);
    check("rst_inst_data", inst_data_o, 32'h0);
    cyc();
    rst = 1'b0;
    cyc();

    // Fetch with ack in cycle 3.
    inst_req_i = 1'b1; inst_addr_i = 32'hBFC0_0000;
    #1 check("f_stall_c0", 32'(inst_stallreq_o), 1);
    check("f_req_c0", 32'(bus_req_o), 0);
    cyc();
    #1 check("f_req_c1", 32'(bus_req_o), 1);
    check("f_addr_c1", bus_addr_o, 32'hBFC0_0000);
    check("f_sel_c1", 32'(bus_sel_o), 32'hF);
    cyc();
    cyc();
    bus_ack_i = 1'b1; bus_rdata_i = 32'h3C01_1234;
    #1 check("f_stall_c3", 32'(inst_stallreq_o), 1);
    check("f_req_c3", 32'(bus_req_o), 1);
    cyc();
    bus_ack_i = 1'b0; bus_rdata_i = 32'h0;
    #1 check("f_data_c4", inst_data_o, 32'h3C01_1234);
    check("f_stall_c4", 32'(inst_stallreq_o), 0);
    check("f_req_c4", 32'(bus_req_o), 0);
    cyc();
    inst_req_i = 1'b0;
    cyc(); cyc();

    // Simultaneous load and fetch: data first.
    data_req_i = 1'b1; data_we_i = 1'b0; data_sel_i = 4'hF; data_addr_i = 32'h8000_0010;
    inst_req_i = 1'b1; inst_addr_i = 32'hBFC0_0004;
    cyc();
    #1 check("s_addr_c1", bus_addr_o, 32'h8000_0010);
    check("s_we_c1", 32'(bus_we_o), 0);
    cyc();
    bus_ack_i = 1'b1; bus_rdata_i = 32'h1111_1111;
    cyc();
    bus_ack_i = 1'b0;
    #1 check("s_dstall_c3", 32'(data_stallreq_o), 0);
    check("s_istall_c3", 32'(inst_stallreq_o), 1);
    check("s_drdata_c3", data_rdata_o, 32'h1111_1111);
    check("s_idle_c3", 32'(bus_req_o), 0);
    cyc();
    data_req_i = 1'b0;
    #1 check("s_ireq_c4", 32'(bus_req_o), 1);
    check("s_iaddr_c4", bus_addr_o, 32'hBFC0_0004);
    cyc();
    bus_ack_i = 1'b1; bus_rdata_i = 32'h2222_2222;
    cyc();
    bus_ack_i = 1'b0;
    #1 check("s_idata_c6", inst_data_o, 32'h2222_2222);
    cyc();
    inst_req_i = 1'b0;
    cyc(); cyc();

    // Store completing under a full pipeline stall.
    wr_count = 0;
    data_req_i = 1'b1; data_we_i = 1'b1; data_sel_i = 4'hF;
    data_addr_i = 32'h8000_0020; data_wdata_i = 32'hDEAD_BEEF;
    cyc();
    #1 check("w_we_c1", 32'(bus_we_o), 1);
    check("w_wdata_c1", bus_wdata_o, 32'hDEAD_BEEF);
    cyc();
    bus_ack_i = 1'b1; bus_rdata_i = 32'h5555_5555;
    cyc();
    bus_ack_i = 1'b0; stall_i = 6'b111111;
    for (int i = 0; i < 3; i++) begin
      #1 check("w_dstall_held", 32'(data_stallreq_o), 0);
      check("w_no_reissue", 32'(bus_req_o), 0);
      cyc();
    end
    stall_i = 6'h0;
    #1 check("w_dstall_release", 32'(data_stallreq_o), 0);
    cyc();
    data_req_i = 1'b0; data_we_i = 1'b0;
    cyc(); cyc();
    check("w_one_write", wr_count, 1);

    // Flush during a fetch: stale result discarded, new fetch follows.
    inst_req_i = 1'b1; inst_addr_i = 32'h8000_0100;
    cyc(); cyc();
    flush_i = 1'b1;
    cyc();
    flush_i = 1'b0; inst_addr_i = 32'h8000_0180;
    cyc();
    bus_ack_i = 1'b1; bus_rdata_i = 32'hBADB_AD00;
    cyc();
    bus_ack_i = 1'b0;
    #1 check("x_istall_c5", 32'(inst_stallreq_o), 1);
    check("x_stale_c5", inst_data_o, 32'h2222_2222);
    check("x_idle_c5", 32'(bus_req_o), 0);
    cyc();
    #1 check("x_req_c6", 32'(bus_req_o), 1);
    check("x_addr_c6", bus_addr_o, 32'h8000_0180);
    cyc();
    bus_ack_i = 1'b1; bus_rdata_i = 32'h0C0F_FEE0;
    cyc();
    bus_ack_i = 1'b0;
    #1 check("x_idata_c8", inst_data_o, 32'h0C0F_FEE0);
    cyc();
    inst_req_i = 1'b0;
    cyc();

    // Two loads with immediate acks.
    data_req_i = 1'b1; data_we_i = 1'b0; data_sel_i = 4'hF; data_addr_i = 32'h8000_0040;
    cyc();
    bus_ack_i = 1'b1; bus_rdata_i = 32'hA1A1_A1A1;
    cyc();
    bus_ack_i = 1'b0; data_addr_i = 32'h8000_0044;
    #1 check("b_rdata1", data_rdata_o, 32'hA1A1_A1A1);
    cyc();
    cyc();
    #1 check("b_req2", 32'(bus_req_o), 1);
    check("b_addr2", bus_addr_o, 32'h8000_0044);
    bus_ack_i = 1'b1; bus_rdata_i = 32'hB2B2_B2B2;
    cyc();
    bus_ack_i = 1'b0;
    #1 check("b_rdata2", data_rdata_o, 32'hB2B2_B2B2);
    cyc();
    data_req_i = 1'b0;
    cyc();

    // Reset held two cycles in the middle of a load; a later ack is ignored.
    data_req_i = 1'b1; data_addr_i = 32'h8000_0050;
    cyc(); cyc();
    rst = 1'b1; data_req_i = 1'b0;
    cyc(); cyc();
    #1 check("r_req", 32'(bus_req_o), 0);
    check("r_addr", bus_addr_o, 32'h0);
    check("r_sel", 32'(bus_sel_o), 0);
    check("r_rdata", data_rdata_o, 32'h0);
    rst = 1'b0; bus_ack_i = 1'b1; bus_rdata_i = 32'hDEAD_DEAD;
    cyc();
    bus_ack_i = 1'b0;
    #1 check("r_ack_ignored", data_rdata_o, 32'h0);
    check("r_still_idle", 32'(bus_req_o), 0);
    cyc();

    // Random traffic.
    for (int i = 0; i < 4000; i++) begin
      rst          = ($urandom_range(0, 255) == 0);
      stall_i      = ($urandom_range(0, 3) == 0) ? 6'b111111 : 6'($urandom);
      flush_i      = ($urandom_range(0, 15) == 0);
      inst_req_i   = ($urandom_range(0, 3) != 0);
      inst_addr_i  = $urandom;
      data_req_i   = ($urandom_range(0, 1) == 0);
      data_we_i    = 1'($urandom);
      data_sel_i   = 4'($urandom);
      data_addr_i  = $urandom;
      data_wdata_i = $urandom;
      bus_ack_i    = ($urandom_range(0, 2) == 0);
      bus_rdata_i  = $urandom;
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
